// File: rtl/pipe_flow_ctrl.sv
// Fetch-PC generation and pipeline flow control: it owns the stage valid/PC
// registers and arbitrates memory stall, load-use interlock and redirect.

module pipe_flow_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            vld_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            vld_q,
  output logic [XLEN-1:0] pc_q
);
  logic            vld_d;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    vld_d = vld_q;
    pc_d  = pc_q;
    if (rst) begin
      vld_d = 1'b0;
      pc_d  = '0;
    end else if (en) begin
      vld_d = vld_in;
      pc_d  = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    vld_q <= vld_d;
    pc_q  <= pc_d;
  end
endmodule

module pipe_flow_ctrl #(
  parameter int               XLEN       = 32,
  parameter int               STAGES     = 3,
  parameter logic [XLEN-1:0]  RESET_VEC  = 'h4000_0000,
  parameter int               HAZ_CYCLES = 1,
  parameter int               CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_stall,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_target,
  input  logic                     haz_req,
  output logic [XLEN-1:0]          pc,
  output logic                     fetch_en,
  output logic [STAGES-1:0]        stage_en,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*XLEN-1:0]   stage_pc,
  output logic                     haz_busy,
  output logic [CNT_W-1:0]         cyc_cnt,
  output logic [CNT_W-1:0]         ret_cnt,
  output logic [CNT_W-1:0]         stl_cnt
);
  localparam int HW = 3;

  logic                           adv, intlk, redir;
  logic [XLEN-1:0]                pc_d, pc_q;
  logic                           haz_busy_d, haz_busy_q;
  logic [HW-1:0]                  haz_cnt_d, haz_cnt_q;
  logic [CNT_W-1:0]               cyc_d, cyc_q, ret_d, ret_q, stl_d, stl_q;
  logic [STAGES-1:0]              stg_vld_in;
  logic [STAGES-1:0][XLEN-1:0]    stg_pc_in;
  logic [STAGES-1:0][XLEN-1:0]    spc;

  // Stall dominates everything; an interlock masks any redirect in the same cycle.
  always_comb begin
    adv      = !ext_stall;
    intlk    = adv && (haz_req || haz_busy_q);
    redir    = adv && !intlk && redirect_valid;
    fetch_en = !rst && adv && !intlk;
    stage_en = '0;
    if (!rst && adv) begin
      stage_en    = '1;
      stage_en[0] = !intlk;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (rst)           pc_d = RESET_VEC;
    else if (redir)    pc_d = redirect_target & ~XLEN'(3);
    else if (fetch_en) pc_d = pc_q + XLEN'(4);
  end

  // Stage 1 takes the fetched PC (squashed on redirect); stage 2 takes a
  // bubble while interlocked, still shifting the PC so it stays deterministic.
  always_comb begin
    stg_vld_in[0] = !redir;
    stg_pc_in[0]  = pc_q;
    for (int k = 1; k < STAGES; k++) begin
      stg_vld_in[k] = stage_valid[k-1];
      stg_pc_in[k]  = spc[k-1];
    end
    if (intlk) stg_vld_in[1] = 1'b0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_flow_stage #(.XLEN(XLEN)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (stage_en[k]),
      .vld_in (stg_vld_in[k]),
      .pc_in  (stg_pc_in[k]),
      .vld_q  (stage_valid[k]),
      .pc_q   (spc[k])
    );
  end

  // The first interlock cycle loads HAZ_CYCLES-1; busy drops with the last decrement.
  always_comb begin
    haz_busy_d = haz_busy_q;
    haz_cnt_d  = haz_cnt_q;
    if (rst) begin
      haz_busy_d = 1'b0;
      haz_cnt_d  = '0;
    end else if (intlk) begin
      if (!haz_busy_q) begin
        if (HAZ_CYCLES > 1) begin
          haz_busy_d = 1'b1;
          haz_cnt_d  = HW'(HAZ_CYCLES - 1);
        end
      end else begin
        haz_cnt_d  = haz_cnt_q - HW'(1);
        haz_busy_d = (haz_cnt_q != HW'(1));
      end
    end
  end

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    stl_d = stl_q;
    if (rst) begin
      cyc_d = '0;
      ret_d = '0;
      stl_d = '0;
    end else begin
      if (adv)                          cyc_d = cyc_q + CNT_W'(1);
      if (adv && stage_valid[STAGES-1]) ret_d = ret_q + CNT_W'(1);
      if (ext_stall || intlk)           stl_d = stl_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    haz_busy_q <= haz_busy_d;
    haz_cnt_q  <= haz_cnt_d;
    cyc_q      <= cyc_d;
    ret_q      <= ret_d;
    stl_q      <= stl_d;
  end

  assign pc       = pc_q;
  assign stage_pc = spc;
  assign haz_busy = haz_busy_q;
  assign cyc_cnt  = cyc_q;
  assign ret_cnt  = ret_q;
  assign stl_cnt  = stl_q;
endmodule
